// File: rtl/signal_measure_multi_if.sv
// Request/result bundle of the multi-channel period/high-time/duty meter.
// master drives the request fields, slave (the meter) drives status and results.
interface signal_measure_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             start;
    logic [CH_W-1:0]  ch_sel;
    logic [7:0]       num_cycles;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] period_sum;
    logic [CNT_W-1:0] high_sum;
    logic [CNT_W-1:0] low_sum;
    logic [9:0]       duty_permille;

    modport master (
        output start, ch_sel, num_cycles,
        input  busy, done, timeout, period_sum, high_sum, low_sum, duty_permille
    );

    modport slave (
        input  start, ch_sel, num_cycles,
        output busy, done, timeout, period_sum, high_sum, low_sum, duty_permille
    );
endinterface

// File: rtl/signal_measure_multi.sv
// Multi-channel meter: period/high/low sums and duty permille of one selected channel over N periods.
// Latency: done pulses 12 clk after the terminating rise is seen; timeout aborts after TIMEOUT_CYC idle clocks.
// Backpressure: none; start is accepted only in IDLE and dropped while busy.
module signal_measure_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     sig_in,
    signal_measure_multi_if.slave bus
);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int DV_W      = CNT_W + 10;
    localparam int WD_LAST_I = TIMEOUT_CYC - 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_LAST_I[WD_W-1:0];
    localparam logic [CH_W:0]   NUM_CH_L = NUM_CH[CH_W:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   abort;

    logic [NUM_CH-1:0] sync1_q, sync2_q, dly_q;
    logic [NUM_CH-1:0] rise;

    logic [CH_W-1:0]  ch_q;
    logic [7:0]       n_q;
    logic [7:0]       edge_cnt;
    logic [WD_W-1:0]  wd_q;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [DV_W-1:0]  rem_q;
    logic [DV_W-1:0]  dsh_q;
    logic [9:0]       quo_q;
    logic [3:0]       it_q;
    logic             div_zero_q;

    logic             busy_q, done_q, timeout_q;
    logic [CNT_W-1:0] period_sum_q, high_sum_q, low_sum_q;
    logic [9:0]       duty_q;

    logic             lvl_sel, rise_sel, wd_expire, period_full, last_rise;
    logic [CNT_W-1:0] fin_period, fin_high;
    logic [DV_W-1:0]  dividend;
    logic [CH_W-1:0]  ch_ok;

    // All channels are synchronised continuously so a switch of ch_sel sees settled history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise        = sync2_q & ~dly_q;
    assign lvl_sel     = sync2_q[ch_q];
    assign rise_sel    = rise[ch_q];
    assign wd_expire   = (wd_q == WD_LAST);
    assign period_full = &period_cnt;
    assign last_rise   = rise_sel && ((edge_cnt + 8'd1) == n_q);

    // The terminating MEAS cycle still counts, so the divider is seeded with the post-update sums.
    assign fin_period = period_cnt + CNT_W'(1);
    assign fin_high   = high_cnt + CNT_W'(lvl_sel);
    assign dividend   = DV_W'(fin_high) * DV_W'(1000);
    assign ch_ok      = ({1'b0, bus.ch_sel} >= NUM_CH_L) ? '0 : bus.ch_sel;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_ARM;
            S_ARM: begin
                if (rise_sel) begin
                    state_d = S_MEAS;
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MEAS: begin
                if (period_full) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else if (last_rise) begin
                    state_d = S_DIV;
                end else if (!rise_sel && wd_expire) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV:   if (it_q == 4'd9) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q         <= '0;
            n_q          <= '0;
            edge_cnt     <= '0;
            wd_q         <= '0;
            period_cnt   <= '0;
            high_cnt     <= '0;
            rem_q        <= '0;
            dsh_q        <= '0;
            quo_q        <= '0;
            it_q         <= '0;
            div_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            period_sum_q <= '0;
            high_sum_q   <= '0;
            low_sum_q    <= '0;
            duty_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        ch_q   <= ch_ok;
                        n_q    <= (bus.num_cycles == 8'd0) ? 8'd1 : bus.num_cycles;
                        busy_q <= 1'b1;
                        wd_q   <= '0;
                    end
                end
                S_ARM: begin
                    wd_q       <= rise_sel ? '0 : wd_q + WD_W'(1);
                    period_cnt <= '0;
                    high_cnt   <= '0;
                    edge_cnt   <= '0;
                end
                S_MEAS: begin
                    wd_q       <= rise_sel ? '0 : wd_q + WD_W'(1);
                    period_cnt <= fin_period;
                    high_cnt   <= fin_high;
                    if (rise_sel) edge_cnt <= edge_cnt + 8'd1;
                    if (last_rise) begin
                        rem_q      <= dividend;
                        dsh_q      <= {1'b0, fin_period, 9'b0};
                        quo_q      <= '0;
                        it_q       <= '0;
                        div_zero_q <= (fin_period == '0);
                    end
                end
                S_DIV: begin
                    // Quotient never exceeds 1000, so 10 restoring steps from divisor<<9 suffice.
                    if (rem_q >= dsh_q) begin
                        rem_q <= rem_q - dsh_q;
                        quo_q <= {quo_q[8:0], 1'b1};
                    end else begin
                        quo_q <= {quo_q[8:0], 1'b0};
                    end
                    dsh_q <= dsh_q >> 1;
                    it_q  <= it_q + 4'd1;
                end
                S_DONE: begin
                    period_sum_q <= period_cnt;
                    high_sum_q   <= high_cnt;
                    low_sum_q    <= period_cnt - high_cnt;
                    duty_q       <= div_zero_q ? 10'd0 : quo_q;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: ;
            endcase
            if (abort) begin
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
                busy_q    <= 1'b0;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.timeout       = timeout_q;
    assign bus.period_sum    = period_sum_q;
    assign bus.high_sum      = high_sum_q;
    assign bus.low_sum       = low_sum_q;
    assign bus.duty_permille = duty_q;
endmodule

// File: tb/tb_signal_measure_multi.sv
// Bench for signal_measure_multi: periodic per-channel waveforms from a cycle formula,
// results and done timing predicted arithmetically from period/high/phase.
module tb_signal_measure_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 2;
    localparam int TMO    = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] sig_in = '0;

    int per [NUM_CH];
    int hi  [NUM_CH];
    int ph  [NUM_CH];
    int cyc = 0;

    int     n_checks = 0;
    int     n_errors = 0;
    longint last_p = 0, last_h = 0, last_l = 0, last_d = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signal_measure_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    signal_measure_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .bus(bus)
    );

    // Channel c is high when (cyc - phase) mod P < H; P == 0 means held low.
    initial forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (per[c] > 0) sig_in[c] = (((cyc + per[c] - ph[c]) % per[c]) < hi[c]);
            else            sig_in[c] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_wave(input int c, input int p, input int h, input int phase);
        per[c] = p;
        hi[c]  = h;
        ph[c]  = phase;
    endtask

    task automatic pulse_start(input int ch, input int num, output int s);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.ch_sel     = CH_W'(ch);
        bus.num_cycles = 8'(num);
        s              = cyc + 1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output int dc);
        got = 1'b0;
        dc  = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
    endtask

    // poke > 0: issue a second, different start that many cycles into the measurement.
    task automatic measure(input int ch, input int num, input int poke);
        int     s, n, k0, exp_dc, dc;
        bit     got;
        longint ep, eh;
        idle(5);
        pulse_start(ch, num, s);
        check("busy_after_start", bus.busy, 1);
        n  = (num == 0) ? 1 : num;
        k0 = s - 2;
        while (((k0 + per[ch] - ph[ch]) % per[ch]) != 0) k0++;
        exp_dc = k0 + n * per[ch] + 14;
        if (poke > 0) begin
            idle(poke);
            bus.start      = 1'b1;
            bus.ch_sel     = CH_W'((ch + 1) % NUM_CH);
            bus.num_cycles = 8'd1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            check("busy_after_poke", bus.busy, 1);
        end
        wait_done(4000, got, dc);
        check("done_seen", got, 1);
        if (got) begin
            ep = longint'(n) * per[ch];
            eh = longint'(n) * hi[ch];
            check("done_cycle", dc, exp_dc);
            check("timeout_flag", bus.timeout, 0);
            check("busy_at_done", bus.busy, 0);
            check("period_sum", bus.period_sum, ep);
            check("high_sum", bus.high_sum, eh);
            check("low_sum", bus.low_sum, ep - eh);
            check("duty", bus.duty_permille, (eh * 1000) / ep);
            last_p = ep;
            last_h = eh;
            last_l = ep - eh;
            last_d = (eh * 1000) / ep;
            idle(1);
            check("done_one_cycle", bus.done, 0);
        end
    endtask

    task automatic check_results_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
        check({tag, "_period"}, bus.period_sum, 0);
        check({tag, "_high"}, bus.high_sum, 0);
        check({tag, "_low"}, bus.low_sum, 0);
        check({tag, "_duty"}, bus.duty_permille, 0);
    endtask

    initial begin
        int  s, dc, c1, c2, p;
        bit  got;
        bus.start      = 1'b0;
        bus.ch_sel     = '0;
        bus.num_cycles = '0;
        for (int c = 0; c < NUM_CH; c++) set_wave(c, 0, 0, 0);

        rst = 1'b1;
        idle(3);
        check_results_zero("reset");
        rst = 1'b0;

        set_wave(0, 70, 20, 3);
        set_wave(1, 100, 30, 17);
        set_wave(2, 50, 25, 0);
        set_wave(3, 40, 10, 5);
        measure(1, 4, 0);

        // Silent channel: abort exactly TMO clocks after entering ARM, results untouched.
        set_wave(0, 0, 0, 0);
        idle(5);
        pulse_start(0, 3, s);
        wait_done(TMO + 100, got, dc);
        check("tmo_seen", got, 1);
        if (got) begin
            check("tmo_cycle", dc, s + TMO);
            check("tmo_flag", bus.timeout, 1);
            check("tmo_busy", bus.busy, 0);
            check("tmo_period_hold", bus.period_sum, last_p);
            check("tmo_high_hold", bus.high_sum, last_h);
            check("tmo_low_hold", bus.low_sum, last_l);
            check("tmo_duty_hold", bus.duty_permille, last_d);
        end
        set_wave(0, 70, 20, 3);

        measure(2, 0, 0);
        measure(2, 3, 70);

        // Reset in the middle of a measurement discards everything.
        idle(5);
        pulse_start(1, 4, s);
        idle(150);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_results_zero("midrst");
        rst = 1'b0;
        last_p = 0;
        last_h = 0;
        last_l = 0;
        last_d = 0;
        measure(1, 4, 0);

        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                p = $urandom_range(150, 4);
                set_wave(c, p, $urandom_range(p - 1, 1), $urandom_range(p - 1, 0));
            end
            c1 = $urandom_range(NUM_CH - 1, 0);
            c2 = (c1 + $urandom_range(NUM_CH - 1, 1)) % NUM_CH;
            measure(c1, $urandom_range(6, 0), 0);
            measure(c2, $urandom_range(6, 0), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
